// File: rtl/tmds_channel_receiver.sv
// TMDS per-channel receiver: finds word alignment by counting runs of control
// tokens at one bit offset, then decodes aligned words into de / ctrl / data.
module tmds_channel_receiver #(
  parameter int LOCK_RUN      = 8,
  parameter int SEARCH_WINDOW = 1024
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [9:0] rx_word,
  input  logic       resync,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] data,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int RUN_W = (LOCK_RUN > 1) ? $clog2(LOCK_RUN + 1) : 1;
  localparam int TMO_W = (SEARCH_WINDOW > 2) ? $clog2(SEARCH_WINDOW) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_RUN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SEARCH_WINDOW - 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [RUN_W-1:0] run_reg, run_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic [3:0]       offset_reg, offset_next, offset_inc;

  logic [9:0]       prev_reg;
  logic [9:0]       q_reg;
  logic [19:0]      window;
  logic [9:0]       cand [10];
  logic [9:0]       aligned;

  logic             is_token;
  logic [1:0]       tok_ctrl;
  logic [7:0]       d_word;
  logic [7:0]       dec_byte;

  logic             de_reg;
  logic [1:0]       ctrl_reg;
  logic [7:0]       data_reg;

  // Two consecutive raw words cover every possible 10-bit alignment.
  assign window = {rx_word, prev_reg};

  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_cand
      assign cand[gi] = window[gi + 9 : gi];
    end
  endgenerate

  assign aligned    = (offset_reg < 4'd10) ? cand[offset_reg] : cand[0];
  assign offset_inc = (offset_reg == 4'd9) ? 4'd0 : offset_reg + 4'd1;

  always_comb begin
    is_token = 1'b1;
    tok_ctrl = 2'b00;
    case (q_reg)
      10'b1101010100: tok_ctrl = 2'b00;
      10'b0010101011: tok_ctrl = 2'b01;
      10'b0101010100: tok_ctrl = 2'b10;
      10'b1010101011: tok_ctrl = 2'b11;
      default:        is_token = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR / XNOR transition chain.
  assign d_word      = q_reg[9] ? ~q_reg[7:0] : q_reg[7:0];
  assign dec_byte[0] = d_word[0];

  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_dec
      assign dec_byte[gi] = q_reg[8] ? (d_word[gi] ^ d_word[gi-1])
                                     : ~(d_word[gi] ^ d_word[gi-1]);
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    run_next    = run_reg;
    tmo_next    = tmo_reg;
    offset_next = offset_reg;
    if (resync) begin
      state_next  = SEARCH;
      run_next    = '0;
      tmo_next    = '0;
      offset_next = offset_inc;
    end else begin
      case (state_reg)
        SEARCH: begin
          if (is_token) begin
            tmo_next = '0;
            if (run_reg == RUN_LAST) begin
              state_next = LOCKED;
              run_next   = '0;
            end else begin
              run_next = run_reg + RUN_W'(1);
            end
          end else if (tmo_reg == TMO_LAST) begin
            offset_next = offset_inc;
            run_next    = '0;
            tmo_next    = '0;
          end else begin
            run_next = '0;
            tmo_next = tmo_reg + TMO_W'(1);
          end
        end
        LOCKED: begin
          if (is_token) begin
            tmo_next = '0;
          end else if (tmo_reg == TMO_LAST) begin
            state_next  = SEARCH;
            offset_next = offset_inc;
            run_next    = '0;
            tmo_next    = '0;
          end else begin
            tmo_next = tmo_reg + TMO_W'(1);
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= SEARCH;
      run_reg    <= '0;
      tmo_reg    <= '0;
      offset_reg <= 4'd0;
      prev_reg   <= 10'd0;
      q_reg      <= 10'd0;
      de_reg     <= 1'b0;
      ctrl_reg   <= 2'b00;
      data_reg   <= 8'h00;
    end else begin
      state_reg  <= state_next;
      run_reg    <= run_next;
      tmo_reg    <= tmo_next;
      offset_reg <= offset_next;
      prev_reg   <= rx_word;
      q_reg      <= aligned;
      // Gate on the pre-update state so the locking token itself stays hidden.
      de_reg     <= (state_reg == LOCKED) && !is_token;
      ctrl_reg   <= ((state_reg == LOCKED) && is_token) ? tok_ctrl : 2'b00;
      data_reg   <= ((state_reg == LOCKED) && !is_token) ? dec_byte : 8'h00;
    end
  end

  assign de     = de_reg;
  assign ctrl   = ctrl_reg;
  assign data   = data_reg;
  assign locked = (state_reg == LOCKED);
  assign offset = offset_reg;

endmodule

// File: tb/tb_tmds_channel_receiver.sv
// Directed-vector bench for tmds_channel_receiver (LOCK_RUN=8, SEARCH_WINDOW=16).
module tb_tmds_channel_receiver;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic       clk_pixel = 1'b0;
  logic       reset_n   = 1'b0;
  logic [9:0] rx_word   = 10'd0;
  logic       resync    = 1'b0;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] data;
  logic       locked;
  logic [3:0] offset;

  int total = 0;
  int bad   = 0;
  bit sq[$];

  tmds_channel_receiver #(.LOCK_RUN(8), .SEARCH_WINDOW(16)) dut (
    .clk_pixel(clk_pixel),
    .reset_n  (reset_n),
    .rx_word  (rx_word),
    .resync   (resync),
    .de       (de),
    .ctrl     (ctrl),
    .data     (data),
    .locked   (locked),
    .offset   (offset)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic step(input logic [9:0] w, input logic rs);
    rx_word = w;
    resync  = rs;
    @(posedge clk_pixel);
    #1;
    resync  = 1'b0;
  endtask

  task automatic push_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) sq.push_back(s[i]);
  endtask

  task automatic push_zero(input int n);
    for (int i = 0; i < n; i++) sq.push_back(1'b0);
  endtask

  task automatic step_stream(input logic rs);
    logic [9:0] w;
    w = 10'd0;
    for (int i = 0; i < 10; i++) if (sq.size() > 0) w[i] = sq.pop_front();
    step(w, rs);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx_word = 10'd0;
    resync  = 1'b0;
    sq.delete();
    repeat (2) @(posedge clk_pixel);
    #3 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk_pixel);
    #1;
    total++; if (de !== 1'b0) begin bad++; $display("FAIL reset_de: got %b want 0", de); end
    total++; if (ctrl !== 2'b00) begin bad++; $display("FAIL reset_ctrl: got %b want 00", ctrl); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    total++; if (offset !== 4'd0) begin bad++; $display("FAIL reset_offset: got %0d want 0", offset); end
    $display("test_reset: outputs checked in reset");
  endtask

  // Stream shifted by 3 bits: sweep offsets 0..3, lock at 3, decode 0x10A -> 0x1E.
  task automatic test_search_lock();
    do_reset();
    push_zero(3);
    repeat (60) push_sym(T00);
    push_sym(10'h10A);
    repeat (5) push_sym(T00);
    for (int k = 0; k < 64; k++) begin
      step_stream(1'b0);
      if (k == 14) begin total++; if (offset !== 4'd0) begin bad++; $display("FAIL sweep_off0: got %0d want 0", offset); end end
      if (k == 15) begin total++; if (offset !== 4'd1) begin bad++; $display("FAIL sweep_off1: got %0d want 1", offset); end end
      if (k == 31) begin total++; if (offset !== 4'd2) begin bad++; $display("FAIL sweep_off2: got %0d want 2", offset); end end
      if (k == 47) begin total++; if (offset !== 4'd3) begin bad++; $display("FAIL sweep_off3: got %0d want 3", offset); end end
      if (k == 55) begin total++; if (locked !== 1'b0) begin bad++; $display("FAIL sweep_prelock: got %b want 0", locked); end end
      if (k == 56) begin total++; if (locked !== 1'b1) begin bad++; $display("FAIL sweep_lock: got %b want 1", locked); end end
      if (k == 61) begin total++; if (de !== 1'b0) begin bad++; $display("FAIL sweep_tok_de: got %b want 0", de); end end
      if (k == 62) begin
        total++; if (de !== 1'b1) begin bad++; $display("FAIL sweep_data_de: got %b want 1", de); end
        total++; if (data !== 8'h1E) begin bad++; $display("FAIL sweep_data: got %h want 1e", data); end
      end
      if (k == 63) begin total++; if (de !== 1'b0) begin bad++; $display("FAIL sweep_after_de: got %b want 0", de); end end
    end
    $display("test_search_lock: offset=%0d locked=%b", offset, locked);
  endtask

  task automatic test_aligned_lock();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step((k == 12) ? 10'b0100000001 : T10, 1'b0);
      if (k == 8) begin total++; if (locked !== 1'b0) begin bad++; $display("FAIL al_prelock: got %b want 0", locked); end end
      if (k == 9) begin
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL al_lock: got %b want 1", locked); end
        total++; if (ctrl !== 2'b00) begin bad++; $display("FAIL al_gated_ctrl: got %b want 00", ctrl); end
      end
      if (k == 10 || k == 13 || k == 15) begin
        total++; if (de !== 1'b0) begin bad++; $display("FAIL al_tok_de k=%0d: got %b want 0", k, de); end
        total++; if (ctrl !== 2'b10) begin bad++; $display("FAIL al_tok_ctrl k=%0d: got %b want 10", k, ctrl); end
      end
      if (k == 14) begin
        total++; if (de !== 1'b1) begin bad++; $display("FAIL al_data_de: got %b want 1", de); end
        total++; if (data !== 8'h03) begin bad++; $display("FAIL al_data: got %h want 03", data); end
      end
    end
    $display("test_aligned_lock: locked=%b ctrl=%b", locked, ctrl);
  endtask

  task automatic test_decode_table();
    logic [9:0] wv [20];
    logic       ev_de [20];
    logic [1:0] ev_ctrl [20];
    logic [7:0] ev_data [20];
    for (int i = 0; i < 20; i++) begin
      wv[i] = T00; ev_de[i] = 1'b0; ev_ctrl[i] = 2'b00; ev_data[i] = 8'h00;
    end
    wv[11] = T01;     ev_ctrl[11] = 2'b01;
    wv[12] = T10;     ev_ctrl[12] = 2'b10;
    wv[13] = T11;     ev_ctrl[13] = 2'b11;
    wv[14] = 10'h100; ev_de[14] = 1'b1; ev_data[14] = 8'h00;
    wv[15] = 10'h200; ev_de[15] = 1'b1; ev_data[15] = 8'hFF;
    wv[16] = 10'h133; ev_de[16] = 1'b1; ev_data[16] = 8'h55;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(wv[i], 1'b0);
      if (i >= 12 && i <= 18) begin
        total++;
        if (de !== ev_de[i-2]) begin bad++; $display("FAIL tbl_de w=%h: got %b want %b", wv[i-2], de, ev_de[i-2]); end
        if (ev_de[i-2]) begin
          total++;
          if (data !== ev_data[i-2]) begin bad++; $display("FAIL tbl_data w=%h: got %h want %h", wv[i-2], data, ev_data[i-2]); end
        end else begin
          total++;
          if (ctrl !== ev_ctrl[i-2]) begin bad++; $display("FAIL tbl_ctrl w=%h: got %b want %b", wv[i-2], ctrl, ev_ctrl[i-2]); end
        end
      end
    end
    $display("test_decode_table: done");
  endtask

  task automatic test_timeout_drop();
    do_reset();
    for (int k = 0; k < 30; k++) begin
      step((k < 10) ? T00 : 10'h100, 1'b0);
      if (k == 26) begin total++; if (locked !== 1'b1 || offset !== 4'd0) begin bad++; $display("FAIL drop_hold: locked=%b offset=%0d want 1/0", locked, offset); end end
      if (k == 27) begin total++; if (locked !== 1'b0 || offset !== 4'd1) begin bad++; $display("FAIL drop: locked=%b offset=%0d want 0/1", locked, offset); end end
    end
    $display("test_timeout_drop: locked=%b offset=%0d", locked, offset);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 25; k++) begin
      step(10'd0, (k < 9) ? 1'b1 : 1'b0);
      if (k == 8 || k == 23) begin total++; if (offset !== 4'd9) begin bad++; $display("FAIL wrap_at9 k=%0d: got %0d want 9", k, offset); end end
      if (k == 24) begin total++; if (offset !== 4'd0) begin bad++; $display("FAIL wrap_to0: got %0d want 0", offset); end end
    end
    $display("test_wrap: offset=%0d", offset);
  endtask

  task automatic test_no_lock();
    logic [9:0] w;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      w = (k < 7 || (k > 7 && k < 15)) ? T00 : ((k == 7) ? 10'h100 : 10'd0);
      step(w, 1'b0);
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL nolock k=%0d: got %b want 0", k, locked); end
    end
    $display("test_no_lock: locked=%b", locked);
  endtask

  task automatic test_resync();
    int n;
    do_reset();
    push_zero(4);
    repeat (40) push_sym(T00);
    for (int k = 0; k < 4; k++) step_stream(1'b1);
    total++; if (offset !== 4'd4) begin bad++; $display("FAIL rs_offset4: got %0d want 4", offset); end
    n = 0;
    while (locked !== 1'b1 && n < 30) begin step_stream(1'b0); n++; end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL rs_lock_wait: locked=%b want 1", locked); end
    step_stream(1'b1);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rs_unlock: got %b want 0", locked); end
    total++; if (offset !== 4'd5) begin bad++; $display("FAIL rs_offset5: got %0d want 5", offset); end
    $display("test_resync: locked=%b offset=%0d", locked, offset);
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    push_zero(2);
    repeat (20) push_sym(T11);
    repeat (6) push_sym(10'h200);
    step_stream(1'b1);
    step_stream(1'b1);
    n = 0;
    while (de !== 1'b1 && n < 40) begin step_stream(1'b0); n++; end
    total++; if (de !== 1'b1 || data !== 8'hFF) begin bad++; $display("FAIL ar_pre_data: de=%b data=%h want 1/ff", de, data); end
    total++; if (locked !== 1'b1 || offset !== 4'd2) begin bad++; $display("FAIL ar_pre_lock: locked=%b offset=%0d want 1/2", locked, offset); end
    #3 reset_n = 1'b0;
    #1;
    total++; if (de !== 1'b0) begin bad++; $display("FAIL ar_de: got %b want 0", de); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL ar_data: got %h want 00", data); end
    total++; if (ctrl !== 2'b00) begin bad++; $display("FAIL ar_ctrl: got %b want 00", ctrl); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL ar_locked: got %b want 0", locked); end
    total++; if (offset !== 4'd0) begin bad++; $display("FAIL ar_offset: got %0d want 0", offset); end
    #2 reset_n = 1'b1;
    $display("test_async_reset: outputs after async reset checked");
  endtask

  initial begin
    test_reset();
    test_search_lock();
    test_aligned_lock();
    test_decode_table();
    test_timeout_drop();
    test_wrap();
    test_no_lock();
    test_resync();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
